// File: rtl/dsp_chain_pkg.sv
// Shared types and constants for the fp16 sop2 chain scheduler.
package dsp_chain_pkg;

  localparam int unsigned OPND_W      = 256;
  localparam logic [31:0] FP32_ZERO   = 32'h0000_0000;
  localparam int unsigned LATENCY_DEF = 4;
  localparam int unsigned LAT_CNT_W   = 4;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StIssue,
    StWait,
    StDone
  } sched_state_e;

endpackage

// File: rtl/dsp_chain_dot_sched_if.sv
// Job, operand, chain and result signals of the dot-product scheduler.
interface dsp_chain_dot_sched_if #(
  parameter int unsigned LEN_W = 8
);
  import dsp_chain_pkg::*;

  logic              job_valid;
  logic              job_ready;
  logic [LEN_W-1:0]  job_len;
  logic              opnd_valid;
  logic              opnd_ready;
  logic [OPND_W-1:0] opnd_data;
  logic [OPND_W-1:0] chain_opnd;
  logic              chain_issue;
  logic              chain_acc;
  logic [31:0]       chain_fp32_in;
  logic [31:0]       chain_result;
  logic              res_valid;
  logic              res_ready;
  logic [31:0]       res_data;

  modport slave (
    input  job_valid, job_len, opnd_valid, opnd_data, chain_result, res_ready,
    output job_ready, opnd_ready, chain_opnd, chain_issue, chain_acc, chain_fp32_in,
           res_valid, res_data
  );

  modport master (
    output job_valid, job_len, opnd_valid, opnd_data, chain_result, res_ready,
    input  job_ready, opnd_ready, chain_opnd, chain_issue, chain_acc, chain_fp32_in,
           res_valid, res_data
  );

endinterface

// File: rtl/sched_lat_timer.sv
// Down-counter covering the chain latency; last_o marks the cycle the result is valid.
module sched_lat_timer #(
  parameter int unsigned Latency = 4,
  parameter int unsigned CntW    = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic dec_i,
  output logic last_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CntW'(Latency);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CntW'(1));

endmodule

// File: rtl/dsp_chain_dot_sched.sv
// Feeds operand beats to an external 4-stage fp16 sop2 chain and collects the
// accumulated fp32 result; the chain itself does all arithmetic.
module dsp_chain_dot_sched
  import dsp_chain_pkg::*;
#(
  parameter int unsigned LATENCY = LATENCY_DEF,
  parameter int unsigned LEN_W   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  dsp_chain_dot_sched_if.slave  bus,
  output logic                  busy
);

  sched_state_e      state_q, state_d;
  logic [LEN_W-1:0]  beats_q, beats_d;
  logic [31:0]       acc_q, acc_d;
  logic [OPND_W-1:0] chain_opnd_q, chain_opnd_d;
  logic              first_q, first_d;
  logic              chain_issue_q, chain_issue_d;
  logic              chain_acc_q, chain_acc_d;
  logic              job_ready_q, job_ready_d;
  logic              opnd_ready_q, opnd_ready_d;
  logic              res_valid_q, res_valid_d;
  logic              busy_q, busy_d;
  logic              tmr_load, tmr_dec, tmr_last;

  sched_lat_timer #(
    .Latency (LATENCY),
    .CntW    (LAT_CNT_W)
  ) u_lat_timer (
    .clk_i  (clk),
    .rst_ni (reset),
    .load_i (tmr_load),
    .dec_i  (tmr_dec),
    .last_o (tmr_last)
  );

  always_comb begin
    state_d      = state_q;
    beats_d      = beats_q;
    acc_d        = acc_q;
    chain_opnd_d = chain_opnd_q;
    first_d      = first_q;
    tmr_load     = 1'b0;
    tmr_dec      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.job_valid) begin
          beats_d = bus.job_len;
          acc_d   = FP32_ZERO;
          first_d = 1'b1;
          state_d = (bus.job_len == '0) ? StDone : StFetch;
        end
      end
      StFetch: begin
        if (bus.opnd_valid) begin
          chain_opnd_d = bus.opnd_data;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        tmr_load = 1'b1;
        state_d  = StWait;
      end
      StWait: begin
        tmr_dec = 1'b1;
        if (tmr_last) begin
          acc_d   = bus.chain_result;
          beats_d = beats_q - 1'b1;
          first_d = 1'b0;
          state_d = (beats_q == LEN_W'(1)) ? StDone : StFetch;
        end
      end
      StDone: begin
        if (bus.res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered from the next state so they line up with it.
    chain_issue_d = (state_d == StIssue);
    chain_acc_d   = (state_d == StIssue) && !first_d;
    job_ready_d   = (state_d == StIdle);
    opnd_ready_d  = (state_d == StFetch);
    res_valid_d   = (state_d == StDone);
    busy_d        = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      beats_q       <= '0;
      acc_q         <= FP32_ZERO;
      chain_opnd_q  <= '0;
      first_q       <= 1'b1;
      chain_issue_q <= 1'b0;
      chain_acc_q   <= 1'b0;
      job_ready_q   <= 1'b1;
      opnd_ready_q  <= 1'b0;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      beats_q       <= beats_d;
      acc_q         <= acc_d;
      chain_opnd_q  <= chain_opnd_d;
      first_q       <= first_d;
      chain_issue_q <= chain_issue_d;
      chain_acc_q   <= chain_acc_d;
      job_ready_q   <= job_ready_d;
      opnd_ready_q  <= opnd_ready_d;
      res_valid_q   <= res_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.job_ready     = job_ready_q;
  assign bus.opnd_ready    = opnd_ready_q;
  assign bus.chain_opnd    = chain_opnd_q;
  assign bus.chain_issue   = chain_issue_q;
  assign bus.chain_acc     = chain_acc_q;
  assign bus.chain_fp32_in = acc_q;
  assign bus.res_valid     = res_valid_q;
  assign bus.res_data      = acc_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_dsp_chain_dot_sched.sv
// Directed bench for dsp_chain_dot_sched with a behavioural chain and result model.
module tb_dsp_chain_dot_sched;
  import dsp_chain_pkg::*;

  localparam int unsigned LAT = 4;
  localparam int unsigned LW  = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   issue_cnt = 0;

  dsp_chain_dot_sched_if #(.LEN_W(LW)) bus ();

  dsp_chain_dot_sched #(
    .LATENCY (LAT),
    .LEN_W   (LW)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_wide(string name, logic [OPND_W-1:0] act, logic [OPND_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- fp helpers (normal numbers and zero only) ----------------
  function automatic real fp16_to_real(logic [15:0] h);
    real m;
    int  e;
    if (h[14:0] == 15'd0) return 0.0;
    m = 1.0 + real'(h[9:0]) / 1024.0;
    e = int'(h[14:10]) - 15;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return h[15] ? -m : m;
  endfunction

  function automatic real fp32_to_real(logic [31:0] f);
    real m;
    int  e;
    if (f[30:0] == 31'd0) return 0.0;
    m = 1.0 + real'(f[22:0]) / 8388608.0;
    e = int'(f[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return f[31] ? -m : m;
  endfunction

  function automatic logic [31:0] real_to_fp32(real v);
    logic        s;
    real         a;
    int          e;
    logic [22:0] mant;
    if (v == 0.0) return 32'h0;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    mant = 23'($rtoi((a - 1.0) * 8388608.0));
    return {s, 8'(e + 127), mant};
  endfunction

  // One chain pass: 4 stages of top_a*top_b + bot_a*bot_b, plus fp32_in when accumulating.
  function automatic logic [31:0] chain_fn(logic [OPND_W-1:0] op, logic acc, logic [31:0] fin);
    real sum;
    sum = 0.0;
    for (int i = 0; i < 4; i++) begin
      sum += fp16_to_real(op[64*i +: 16]) * fp16_to_real(op[64*i+16 +: 16]);
      sum += fp16_to_real(op[64*i+32 +: 16]) * fp16_to_real(op[64*i+48 +: 16]);
    end
    if (acc) sum += fp32_to_real(fin);
    return real_to_fp32(sum);
  endfunction

  // ---------------- behavioural chain: result valid LAT cycles after issue ----------------
  logic        pipe_v [LAT];
  logic [31:0] pipe_d [LAT];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) pipe_v[i] <= 1'b0;
    end else begin
      pipe_v[0] <= bus.chain_issue;
      pipe_d[0] <= chain_fn(bus.chain_opnd, bus.chain_acc, bus.chain_fp32_in);
      for (int i = 1; i < LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign bus.chain_result = pipe_v[LAT-1] ? pipe_d[LAT-1] : 32'hDEAD_BEEF;

  // ---------------- operand driver ----------------
  logic [OPND_W-1:0] opnd_tab [4];
  int drv_beat = 0, drv_gap_beat = -1, drv_gap_n = 0, drv_gap_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (bus.opnd_ready && drv_beat == drv_gap_beat && drv_gap_cnt < drv_gap_n) begin
      bus.opnd_valid = 1'b0;
      drv_gap_cnt++;
    end else begin
      bus.opnd_valid = 1'b1;
      bus.opnd_data  = opnd_tab[drv_beat % 4];
      if (bus.opnd_ready) drv_beat++;
    end
  end

  // ---------------- job-level model + per-cycle compare ----------------
  logic [31:0]       exp_q[$];
  logic [OPND_W-1:0] m_opnd;
  logic [31:0]       m_acc, prev_data, m_exp;
  logic              m_first, prev_hold, prev_issue;
  int                m_left;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_first    = 1'b1;
      m_acc      = 32'h0;
      m_left     = 0;
      prev_hold  = 1'b0;
      prev_issue = 1'b0;
    end else begin
      chk("busy_vs_job_ready", busy, !bus.job_ready);
      if (bus.opnd_ready) chk("opnd_ready_only_busy", busy, 1);
      if (bus.job_valid && bus.job_ready) begin
        m_left  = int'(bus.job_len);
        m_first = 1'b1;
        m_acc   = 32'h0;
        if (m_left == 0) exp_q.push_back(32'h0);
      end
      if (bus.opnd_valid && bus.opnd_ready) m_opnd = bus.opnd_data;
      if (bus.chain_issue) begin
        issue_cnt++;
        chk("issue_single_cycle", prev_issue, 0);
        chk_wide("chain_opnd", bus.chain_opnd, m_opnd);
        chk("chain_acc", bus.chain_acc, !m_first);
        chk("chain_fp32_in", bus.chain_fp32_in, m_acc);
        m_acc   = chain_fn(m_opnd, !m_first, m_acc);
        m_first = 1'b0;
        m_left--;
        if (m_left == 0) exp_q.push_back(m_acc);
      end
      prev_issue = bus.chain_issue;
      if (prev_hold) begin
        chk("res_valid_held", bus.res_valid, 1);
        chk("res_data_stable", bus.res_data, prev_data);
      end
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          m_exp = exp_q.pop_front();
          chk("res_data_model", bus.res_data, m_exp);
        end
      end
      prev_hold = bus.res_valid && !bus.res_ready;
      prev_data = bus.res_data;
    end
  end

  // ---------------- directed job task ----------------
  task automatic run_job(string name, int len, int gap_beat, int gap_n, int rr_low, logic spam,
                         int exp_cyc, logic [31:0] exp_data);
    int t0, n, iss0;
    drv_beat     = 0;
    drv_gap_beat = gap_beat;
    drv_gap_n    = gap_n;
    drv_gap_cnt  = 0;
    bus.res_ready = (rr_low == 0);
    @(posedge clk); #1;
    chk({name, "_job_ready"}, bus.job_ready, 1);
    iss0 = issue_cnt;
    bus.job_valid = 1'b1;
    bus.job_len   = LW'(len);
    t0 = cyc;
    @(posedge clk); #1;
    if (spam) bus.job_len = LW'(len + 3);
    else bus.job_valid = 1'b0;
    n = 0;
    while (!bus.res_valid && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    bus.job_valid = 1'b0;
    chk({name, "_res_cycle"}, cyc - t0, exp_cyc);
    chk({name, "_res_data"}, bus.res_data, exp_data);
    chk({name, "_issues"}, issue_cnt - iss0, len);
    if (rr_low > 0) begin
      repeat (rr_low) begin @(posedge clk); #1; end
      chk({name, "_res_after_hold"}, bus.res_data, exp_data);
      bus.res_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk({name, "_idle_after"}, bus.job_ready, 1);
    chk({name, "_res_dropped"}, bus.res_valid, 0);
  endtask

  task automatic chk_reset_outputs(string name);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_job_ready"}, bus.job_ready, 1);
    chk({name, "_opnd_ready"}, bus.opnd_ready, 0);
    chk({name, "_res_valid"}, bus.res_valid, 0);
    chk({name, "_issue"}, bus.chain_issue, 0);
    chk({name, "_acc"}, bus.chain_acc, 0);
    chk({name, "_fp32_in"}, bus.chain_fp32_in, 32'h0);
    chk_wide({name, "_opnd"}, bus.chain_opnd, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst_n = 1'b0;
    bus.job_valid = 1'b0;
    bus.job_len   = '0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 4; i++) opnd_tab[i] = {16{16'h3C00}};
    chk("pin_one_times_8", real_to_fp32(fp16_to_real(16'h3C00) * 8.0), 32'h4100_0000);
    chk("pin_mixed_34", real_to_fp32(fp16_to_real(16'h4000) * 16.0 + 2.0), 32'h4208_0000);
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    run_job("len1", 1, -1, 0, 0, 1'b0, 7, 32'h4100_0000);
    run_job("len3", 3, -1, 0, 0, 1'b0, 19, 32'h41C0_0000);
    run_job("len0", 0, -1, 0, 0, 1'b0, 1, 32'h0000_0000);
    run_job("gap", 2, 1, 5, 3, 1'b1, 18, 32'h4180_0000);
    opnd_tab[0] = {16{16'h4000}};
    opnd_tab[1] = {16{16'h3800}};
    run_job("mixed", 2, -1, 0, 0, 1'b0, 13, 32'h4208_0000);
    for (int i = 0; i < 4; i++) opnd_tab[i] = {16{16'h3C00}};

    // Reset in the WAIT of beat 2, then a fresh single-beat job.
    drv_beat = 0; drv_gap_beat = -1; drv_gap_n = 0; drv_gap_cnt = 0;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.job_valid = 1'b1;
    bus.job_len   = LW'(3);
    t0 = cyc;
    @(posedge clk); #1;
    bus.job_valid = 1'b0;
    while (cyc < t0 + 9) begin @(posedge clk); #1; end
    chk("midjob_busy", busy, 1);
    chk("midjob_fp32_in", bus.chain_fp32_in, 32'h4100_0000);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_job("after_reset", 1, -1, 0, 0, 1'b0, 7, 32'h4100_0000);

    repeat (5) @(posedge clk);
    #1;
    chk("no_leftover_results", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsp_chain_dot_sched.md
DSP_CHAIN_DOT_SCHED -- requirements
Module: dsp_chain_dot_sched

Interface
REQ-001 SHALL have parameter LATENCY, default 4: cycles from the chain_issue cycle to a valid chain_result (range 1..15).
REQ-002 SHALL have parameter LEN_W, default 8: width of job_len.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports job_valid (in, 1), job_ready (out, 1), job_len (in, LEN_W): job request; job_len is the number of operand beats.
REQ-006 SHALL have ports opnd_valid (in, 1), opnd_ready (out, 1), opnd_data (in, 256): one beat of 16 fp16 operands (top_a/top_b/bot_a/bot_b for 4 stages, stage1 in LSBs).
REQ-007 SHALL have ports chain_opnd (out, 256), chain_issue (out, 1), chain_acc (out, 1), chain_fp32_in (out, 32): drive to the 4-stage fp16 sop2 chain.
REQ-008 SHALL have port chain_result, input, 32: fp32 output of the last chain stage.
REQ-009 SHALL have ports res_valid (out, 1), res_ready (in, 1), res_data (out, 32): job result.
REQ-010 SHALL have port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, FETCH, ISSUE, WAIT and DONE.
REQ-012 IDLE: job_ready=1; on job_valid, latch job_len and clear acc; go to FETCH, or to DONE if job_len==0.
REQ-013 FETCH: opnd_ready=1; on opnd_valid, register opnd_data into chain_opnd and go to ISSUE; with no opnd_valid, hold FETCH indefinitely.
REQ-014 ISSUE: chain_issue=1 for exactly one cycle; chain_acc=0 on the first beat of a job and 1 on later beats; chain_fp32_in=acc; load the latency counter with LATENCY; go to WAIT.
REQ-015 WAIT: decrement the counter each cycle; in the cycle the counter reaches 1, capture chain_result into acc and decrement the remaining beat count; go to DONE if no beats remain, else to FETCH.
REQ-016 DONE: res_valid=1 and res_data=acc, both held stable until res_ready; on res_ready go to IDLE.
REQ-017 Timing, LATENCY=4, operands always valid, job accepted in cycle 0: beat k handshakes in cycle 1+6k; res_valid first asserts in cycle 1+6K for K beats.
REQ-018 job_len==0: res_valid in cycle 1 after acceptance, res_data=0x00000000, chain_issue never asserted.
REQ-019 job_valid outside IDLE SHALL be ignored; opnd_ready SHALL be 0 outside FETCH.
REQ-020 chain_opnd SHALL hold its value between issues; chain_fp32_in SHALL equal acc at all times.
REQ-021 The block SHALL perform no fp arithmetic; accumulation is done by the chain via chain_acc/chain_fp32_in.

Reset
REQ-022 On reset low, asynchronously: state=IDLE, acc=0, beat and latency counters=0, chain_opnd=0, chain_issue=0, chain_acc=0, res_valid=0, busy=0.
REQ-023 Reset mid-job SHALL abandon the job with no result emitted; after release, the next job SHALL behave as if it were the first.

Structure
REQ-024 Package dsp_chain_pkg SHALL hold the state enum, OPND_W=256, FP32_ZERO, and the LATENCY default.
REQ-025 Sub-module sched_lat_timer (load, decrement, last-cycle flag) SHALL implement the WAIT counter.

Verification
REQ-026 Chain modelled behaviourally (per-beat sum of 8 products, plus fp32_in when chain_acc=1, delayed LATENCY cycles).
REQ-027 job_len=1, all operands 0x3C00 -> res_data=0x41000000, res_valid in cycle 7.
REQ-028 job_len=3, all 0x3C00, res_ready=1 -> res_data=0x41C00000 in cycle 19; job_ready high in cycle 20.
REQ-029 job_len=0 -> res_valid in cycle 1, res_data=0, zero chain_issue pulses.
REQ-030 job_len=2, opnd_valid low for 5 cycles before beat 2 -> FETCH held, result 0x41800000 in cycle 18; res_ready low 3 cycles -> res_data stable.
REQ-031 Reset asserted in WAIT of beat 2 -> all outputs at reset values immediately; new job_len=1 -> 0x41000000 with chain_acc=0.
